// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex seven-segment driver with shadowed display data,
// per-digit blanking/decimal point, leading-zero suppression and registered outputs.
module seven_seg_scan_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic          INV        = (ACTIVE_LOW != 0);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_out_q, dp_out_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic [DIGITS-1:0]     lz_sup;
    logic [DIGITS-1:0]     dark;
    logic                  run_zero;
    logic [3:0]            cur_nib;
    logic                  cur_dark;
    logic                  cur_dp;
    logic [6:0]            seg_act;
    logic [DIGITS-1:0]     an_act;

    function automatic logic [6:0] enc7(input logic [3:0] n);
        case (n)
            4'h0:    enc7 = 7'h3F;
            4'h1:    enc7 = 7'h06;
            4'h2:    enc7 = 7'h5B;
            4'h3:    enc7 = 7'h4F;
            4'h4:    enc7 = 7'h66;
            4'h5:    enc7 = 7'h6D;
            4'h6:    enc7 = 7'h7D;
            4'h7:    enc7 = 7'h07;
            4'h8:    enc7 = 7'h7F;
            4'h9:    enc7 = 7'h6F;
            4'hA:    enc7 = 7'h77;
            4'hB:    enc7 = 7'h7C;
            4'hC:    enc7 = 7'h39;
            4'hD:    enc7 = 7'h5E;
            4'hE:    enc7 = 7'h79;
            default: enc7 = 7'h71;
        endcase
    endfunction

    // Scan timing and shadow capture
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        value_d = value_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        if (load) begin
            value_d = value;
            dp_d    = dp;
            blank_d = blank;
        end
    end

    // Walk from the most significant nibble down; a digit is suppressed while
    // every nibble from it upward is zero. Digit 0 is never suppressed.
    always_comb begin
        run_zero = 1'b1;
        lz_sup   = '0;
        for (int unsigned k = DIGITS; k > 0; k--) begin
            run_zero = run_zero && (value_q[4*(k-1) +: 4] == 4'h0);
            if (k > 1) begin
                lz_sup[k-1] = lz_en && run_zero;
            end
        end
        dark = blank_q | lz_sup;
    end

    always_comb begin
        cur_nib  = '0;
        cur_dark = 1'b1;
        cur_dp   = 1'b0;
        an_act   = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = value_q[4*k +: 4];
                cur_dark  = dark[k];
                cur_dp    = dp_q[k];
                an_act[k] = !dark[k];
            end
        end
        seg_act  = cur_dark ? 7'h00 : enc7(cur_nib);
        seg_d    = seg_act ^ {7{INV}};
        dp_out_d = (cur_dp && !cur_dark) ^ INV;
        an_d     = an_act ^ {DIGITS{INV}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            value_q  <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            seg_q    <= {7{INV}};
            dp_out_q <= INV;
            an_q     <= {DIGITS{INV}};
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
            an_q     <= an_d;
        end
    end

    assign seg    = seg_q;
    assign dp_out = dp_out_q;
    assign an     = an_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1).
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic        load;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;

    int total = 0;
    int bad   = 0;

    // Bench-side scan position: m_* is state after the last edge, o_* is the
    // state the outputs currently reflect (state before the last edge).
    int m_presc = 0;
    int m_idx   = 0;
    int o_presc = -1;
    int o_idx   = -1;

    logic [6:0] inv_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_scan_driver #(
        .DIGITS      (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .value  (value),
        .dp     (dp),
        .blank  (blank),
        .lz_en  (lz_en),
        .load   (load),
        .seg    (seg),
        .dp_out (dp_out),
        .an     (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_presc = 0;
            m_idx   = 0;
            o_presc = -1;
            o_idx   = -1;
        end else begin
            o_presc = m_presc;
            o_idx   = m_idx;
            if (m_presc == 3) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % 4;
            end else begin
                m_presc++;
            end
        end
        @(negedge clk);
    endtask

    task automatic to_slot(input int d);
        for (int i = 0; i < 40; i++) begin
            if (o_idx == d && o_presc == 0) break;
            tick();
        end
    endtask

    // Check every cycle of digit d's slot
    task automatic check_slot(input string tag, input int d, input logic [3:0] e_an,
                              input logic [6:0] e_seg, input logic e_dp);
        to_slot(d);
        for (int c = 0; c < 4; c++) begin
            chk({tag, "_an"}, {4'h0, an}, {4'h0, e_an});
            chk({tag, "_seg"}, {1'b0, seg}, {1'b0, e_seg});
            chk({tag, "_dp"}, {7'h0, dp_out}, {7'h0, e_dp});
            if (c < 3) tick();
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v;
        dp    = d;
        blank = b;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; value = '0; dp = '0; blank = '0; lz_en = 1'b0; load = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_dp", {7'h0, dp_out}, 8'h01);
        chk("rst_an", {4'h0, an}, 8'h0F);

        rst = 1'b0;
        tick();
        chk("first_seg", {1'b0, seg}, 8'h40);
        chk("first_an", {4'h0, an}, 8'h0E);

        // Basic scan of 1234
        do_load(16'h1234, 4'b0000, 4'b0000);
        check_slot("s1234_d0", 0, 4'hE, 7'h19, 1'b1);
        check_slot("s1234_d1", 1, 4'hD, 7'h30, 1'b1);
        check_slot("s1234_d2", 2, 4'hB, 7'h24, 1'b1);
        check_slot("s1234_d3", 3, 4'h7, 7'h79, 1'b1);

        // Full encoder sweep on digit 0
        for (int v = 0; v < 16; v++) begin
            do_load(16'(v), 4'b0000, 4'b0000);
            to_slot(0);
            chk($sformatf("sweep_%0h", v), {1'b0, seg}, {1'b0, inv_tab[v]});
        end

        // Leading-zero suppression, then live disable
        lz_en = 1'b1;
        do_load(16'h0070, 4'b0000, 4'b0000);
        check_slot("lz_d3", 3, 4'hF, 7'h7F, 1'b1);
        check_slot("lz_d0", 0, 4'hE, 7'h40, 1'b1);
        check_slot("lz_d1", 1, 4'hD, 7'h78, 1'b1);
        check_slot("lz_d2", 2, 4'hF, 7'h7F, 1'b1);
        lz_en = 1'b0;
        check_slot("nolz_d3", 3, 4'h7, 7'h40, 1'b1);
        check_slot("nolz_d2", 2, 4'hB, 7'h40, 1'b1);

        // All-zero with dp on a suppressed digit, then on digit 0
        lz_en = 1'b1;
        do_load(16'h0000, 4'b0100, 4'b0000);
        check_slot("z_d0", 0, 4'hE, 7'h40, 1'b1);
        check_slot("z_d1", 1, 4'hF, 7'h7F, 1'b1);
        check_slot("z_d2", 2, 4'hF, 7'h7F, 1'b1);
        check_slot("z_d3", 3, 4'hF, 7'h7F, 1'b1);
        do_load(16'h0000, 4'b0001, 4'b0000);
        check_slot("zdp_d0", 0, 4'hE, 7'h40, 1'b0);

        // Blank digit 1 while scanning
        lz_en = 1'b0;
        do_load(16'h1234, 4'b0010, 4'b0010);
        check_slot("blk_d1", 1, 4'hF, 7'h7F, 1'b1);
        check_slot("blk_d2", 2, 4'hB, 7'h24, 1'b1);
        check_slot("blk_d0", 0, 4'hE, 7'h19, 1'b1);

        // Load coinciding with the 0 -> 1 index advance
        for (int i = 0; i < 40; i++) begin
            if (m_presc == 3 && m_idx == 0) break;
            tick();
        end
        value = 16'hABCD; dp = 4'b0000; blank = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("adv_seg", {1'b0, seg}, 8'h46);
        chk("adv_an", {4'h0, an}, 8'h0D);

        // Reset mid-scan at index 2 with a simultaneous load
        for (int i = 0; i < 40; i++) begin
            if (m_presc == 1 && m_idx == 2) break;
            tick();
        end
        rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp = 4'hF;
        tick();
        chk("mrst_seg", {1'b0, seg}, 8'h7F);
        chk("mrst_dp", {7'h0, dp_out}, 8'h01);
        chk("mrst_an", {4'h0, an}, 8'h0F);
        rst = 1'b0; load = 1'b0;
        tick();
        chk("post_seg", {1'b0, seg}, 8'h40);
        chk("post_an", {4'h0, an}, 8'h0E);
        chk("post_dp", {7'h0, dp_out}, 8'h01);
        check_slot("post_d1", 1, 4'hD, 7'h40, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
